// File: rtl/uart_cmd_dispatch.sv
// Receive-side command dispatcher: assembles big-endian UART bytes into 32-bit words and routes them.
// Optional trailing XOR checksum byte is enabled with `define UART_RX_CHECKSUM_EN.
module uart_cmd_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic [31:0] UARTReadMSM,
  output logic        UARTRreqMSM,
  input  logic        UARTRackMSM,
  output logic [31:0] UART2Read,
  output logic        UART2Rreq,
  input  logic        UART2Rack,
  output logic [31:0] UART4Read,
  output logic        UART4Rreq,
  input  logic        UART4Rack,
  output logic        FrameErr,
  output logic        Overrun,
  output logic        ChkErr
);

`ifdef UART_RX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
  localparam int         ASM_W    = 32;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
  localparam int         ASM_W    = 24;
`endif
  localparam logic [19:0] IDLE_MAX = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_ASSEMBLE
  } state_t;

  typedef enum logic [1:0] {
    D_MSM,
    D_U2,
    D_U4
  } dest_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic [19:0]       r_idle;
  logic [ASM_W-1:0]  r_asm;
  logic [31:0]       r_read;
  logic              r_hold_valid;
  dest_t             r_dest;
  logic              r_frame_err;
  logic              r_overrun;

  logic              w_done;
  logic              w_timeout;
  logic [31:0]       w_word;
  logic              w_csum_ok;
  dest_t             w_dest;
  logic              w_ack;
  logic              w_deliver;
  logic              w_load;

  always_comb begin
    // NOTE: every combinational output is given a default first, so no branch can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RxValid) begin
          w_state_nxt = S_ASSEMBLE;
          w_cnt_nxt   = 3'd1;
        end
      end
      S_ASSEMBLE: begin
        if (RxValid) begin
          if (r_cnt == LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else if (r_idle == IDLE_MAX) begin
          // A byte in this same cycle takes the branch above, so it always wins over the timeout.
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

`ifdef UART_RX_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_chk_err;
  logic       w_bad;

  assign w_word    = r_asm;
  assign w_csum_ok = (RxData == r_csum);
  assign w_bad     = w_done & ~w_csum_ok;

  always_ff @(posedge Clk) begin
    if (RxValid) begin
      r_csum <= (r_state == S_IDLE) ? RxData : (r_csum ^ RxData);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_chk_err <= 1'b0;
    end else begin
      r_chk_err <= w_bad;
    end
  end

  assign ChkErr = r_chk_err;
`else
  assign w_word    = {r_asm, RxData};
  assign w_csum_ok = 1'b1;
  assign ChkErr    = 1'b0;
`endif

  always_comb begin
    w_dest = D_MSM;
    if (w_word[31:24] == 8'h02 || w_word[31:24] == 8'h03) begin
      w_dest = D_U2;
    end else if (w_word[31:24] == 8'h04) begin
      w_dest = D_U4;
    end
  end

  assign w_ack = r_hold_valid & (((r_dest == D_MSM) & UARTRackMSM) |
                                 ((r_dest == D_U2)  & UART2Rack)   |
                                 ((r_dest == D_U4)  & UART4Rack));
  assign w_deliver = w_done & w_csum_ok;
  assign w_load    = w_deliver & (~r_hold_valid | w_ack);

  // NOTE: the assembly shifter is pure datapath, fully overwritten before each use, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (RxValid) begin
      r_asm <= {r_asm[ASM_W-9:0], RxData};
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
    if (Rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_idle       <= 20'd0;
      r_read       <= 32'd0;
      r_hold_valid <= 1'b0;
      r_dest       <= D_MSM;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idle      <= (r_state == S_ASSEMBLE && !RxValid && !w_timeout) ? r_idle + 20'd1 : 20'd0;
      r_frame_err <= w_timeout;
      r_overrun   <= w_deliver & r_hold_valid & ~w_ack;
      if (w_load) begin
        r_read       <= w_word;
        r_dest       <= w_dest;
        r_hold_valid <= 1'b1;
      end else if (w_ack) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // One holding register feeds all three buses; only the tagged request is raised.
  assign UARTReadMSM = r_read;
  assign UART2Read   = r_read;
  assign UART4Read   = r_read;
  assign UARTRreqMSM = r_hold_valid & (r_dest == D_MSM);
  assign UART2Rreq   = r_hold_valid & (r_dest == D_U2);
  assign UART4Rreq   = r_hold_valid & (r_dest == D_U4);
  assign FrameErr    = r_frame_err;
  assign Overrun     = r_overrun;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Scoreboard bench for uart_cmd_dispatch: a frame-level reference model predicts requests and error
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_cmd_dispatch;

  localparam int TO = 20;
`ifdef UART_RX_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic [31:0] UARTReadMSM, UART2Read, UART4Read;
  logic        UARTRreqMSM, UART2Rreq, UART4Rreq;
  logic        UARTRackMSM = 1'b0, UART2Rack = 1'b0, UART4Rack = 1'b0;
  logic        FrameErr, Overrun, ChkErr;

  uart_cmd_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .RxData(RxData), .RxValid(RxValid),
    .UARTReadMSM(UARTReadMSM), .UARTRreqMSM(UARTRreqMSM), .UARTRackMSM(UARTRackMSM),
    .UART2Read(UART2Read), .UART2Rreq(UART2Rreq), .UART2Rack(UART2Rack),
    .UART4Read(UART4Read), .UART4Rreq(UART4Rreq), .UART4Rack(UART4Rack),
    .FrameErr(FrameErr), .Overrun(Overrun), .ChkErr(ChkErr)
  );

  always #5 Clk = ~Clk;

  typedef enum int {EV_REQ, EV_FERR, EV_OVR, EV_CHK} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          dest;
    logic [31:0] word;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  mon_en = 1'b0;

  // Reference model state: bytes of the frame in progress, idle gap, and the pending request.
  logic [7:0] partial[$];
  int         gap = 0;
  bit         held = 1'b0;
  int         held_dest = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int route(input logic [7:0] c);
    if (c == 8'h02 || c == 8'h03) return 1;
    if (c == 8'h04) return 2;
    return 0;
  endfunction

  task automatic push_ev(input ev_kind_t k, input int d, input logic [31:0] w);
    ev_t e;
    e.kind = k; e.dest = d; e.word = w; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; ack bit 0 = MSM, 1 = UART2, 2 = UART4.
  task automatic step(input bit v, input logic [7:0] d, input logic [2:0] ack);
    bit          ackhit;
    logic [31:0] w;
    logic [7:0]  x;
    RxValid = v;
    RxData  = d;
    {UART4Rack, UART2Rack, UARTRackMSM} = ack;
    ackhit = held && ack[held_dest];
    if (v) begin
      partial.push_back(d);
      gap = 0;
      if (partial.size() == FLEN) begin
        w = {partial[0], partial[1], partial[2], partial[3]};
        x = partial[0] ^ partial[1] ^ partial[2] ^ partial[3];
        if (FLEN == 5 && partial[FLEN-1] != x) begin
          push_ev(EV_CHK, 0, 32'h0);
        end else if (held && !ackhit) begin
          push_ev(EV_OVR, 0, 32'h0);
        end else begin
          push_ev(EV_REQ, route(w[31:24]), w);
          held = 1'b1;
          held_dest = route(w[31:24]);
          ackhit = 1'b0;
        end
        partial.delete();
      end
    end else if (partial.size() > 0) begin
      gap++;
      if (gap == TO) begin
        push_ev(EV_FERR, 0, 32'h0);
        partial.delete();
        gap = 0;
      end
    end
    if (ackhit) held = 1'b0;
    @(posedge Clk);
    #1;
    RxValid = 1'b0;
    {UART4Rack, UART2Rack, UARTRackMSM} = 3'b000;
  endtask

  task automatic idle(input int n, input logic [2:0] ack);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ack);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [2:0] last_ack, input bit bad_cs);
    logic [7:0] b;
    logic [7:0] x;
    x = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    for (int i = 0; i < FLEN; i++) begin
      b = (i < 4) ? w[31-8*i -: 8] : (x ^ {7'd0, bad_cs});
      step(1'b1, b, (i == FLEN - 1) ? last_ack : 3'b000);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {UARTRreqMSM, UART2Rreq, UART4Rreq, FrameErr, Overrun, ChkErr,
                 UARTReadMSM, UART2Read, UART4Read}, 128'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #1;
    mon_en = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check_reset_outputs("reset_outputs");
    check("exp_q_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    partial.delete();
    gap = 0;
    held = 1'b0;
    Rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: a request is "presented" when its Rreq rises, or stays high right after an ack was sampled.
  logic [2:0] mon_reqs;
  logic [2:0] prev_reqs = 3'b000;
  logic [2:0] samp_ack  = 3'b000;

  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    samp_ack <= {UART4Rack, UART2Rack, UARTRackMSM};
  end

  task automatic got_event(input ev_kind_t k, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d dest %0d want none (cycle %0d)", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (k == EV_REQ && e.kind == EV_REQ) begin
        check("req_dest", d, e.dest);
        check("read_buses", {UARTReadMSM, UART2Read, UART4Read}, {e.word, e.word, e.word});
      end
    end
  endtask

  always @(negedge Clk) begin
    mon_reqs = {UART4Rreq, UART2Rreq, UARTRreqMSM};
    if (!Rst && mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (mon_reqs[i] && (!prev_reqs[i] || samp_ack[i])) got_event(EV_REQ, i);
      end
      if (FrameErr) got_event(EV_FERR, 0);
      if (Overrun)  got_event(EV_OVR, 0);
      if (ChkErr)   got_event(EV_CHK, 0);
      if (mon_reqs != 3'b000) check("req_onehot", $countones(mon_reqs), 1);
    end
    prev_reqs = mon_reqs;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, exp_q=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [2:0]  a;
    int          g;
    int          r;

    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("initial_reset");
    Rst = 1'b0;
    mon_en = 1'b1;

    // Basic UART4 delivery, then ack drops the request next cycle.
    send_frame(32'h04112233, 3'b000, 1'b0);
    check("u4_req_high", {UART4Rreq, UART2Rreq, UARTRreqMSM}, 3'b100);
    idle(2, 3'b000);
    step(1'b0, 8'h00, 3'b011);
    check("u4_ignores_foreign_ack", UART4Rreq, 1'b1);
    step(1'b0, 8'h00, 3'b100);
    check("u4_req_drop", UART4Rreq, 1'b0);
    check("u4_read_holds", UART4Read, 32'h04112233);

    // UART2, UART2, then MSM, each acked in its first request cycle.
    send_frame(32'h02AABBCC, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b010);
    send_frame(32'h03010203, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b010);
    send_frame(32'hA5000001, 3'b000, 1'b0);
    check("msm_read", UARTReadMSM, 32'hA5000001);
    step(1'b0, 8'h00, 3'b001);

    // Timeout after two bytes, then a clean word.
    step(1'b1, 8'h11, 3'b000);
    step(1'b1, 8'h22, 3'b000);
    idle(TO, 3'b000);
    send_frame(32'h01020304, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b001);

    // Byte exactly in the timeout cycle is accepted.
    step(1'b1, 8'h04, 3'b000);
    step(1'b1, 8'h55, 3'b000);
    idle(TO - 1, 3'b000);
    for (int i = 2; i < FLEN; i++) step(1'b1, 8'h66, 3'b000);
    check("timeout_edge_no_ferr", FrameErr, 1'b0);
    step(1'b0, 8'h00, 3'b100);

    // Overrun keeps the held word; then ack in the completion cycle avoids overrun.
    send_frame(32'h04DEAD01, 3'b000, 1'b0);
    send_frame(32'h02BEEF02, 3'b000, 1'b0);
    check("overrun_retains_word", UART4Read, 32'h04DEAD01);
    check("overrun_retains_req", {UART4Rreq, UART2Rreq}, 2'b10);
    send_frame(32'h02BEEF03, 3'b100, 1'b0);
    step(1'b0, 8'h00, 3'b010);

    // Reset mid-word and with a held request.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h04, 3'b000);
    do_reset();
    send_frame(32'hA5C3F00F, 3'b000, 1'b0);
    do_reset();
    send_frame(32'h03123456, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b010);

`ifdef UART_RX_CHECKSUM_EN
    send_frame(32'h04112233, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b100);
    send_frame(32'h04112233, 3'b000, 1'b1);
    idle(2, 3'b000);
`endif

    // Randomized traffic: random commands, gaps around the timeout boundary, random acks.
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 3);
      w = $urandom();
      case (r)
        0: w[31:24] = 8'h02;
        1: w[31:24] = 8'h03;
        2: w[31:24] = 8'h04;
        default: ;
      endcase
      for (int i = 0; i < FLEN; i++) begin
        r = $urandom_range(0, 19);
        if (r < 14)      g = $urandom_range(0, 2);
        else if (r < 16) g = TO - 1;
        else if (r < 18) g = TO;
        else             g = TO + 3;
        for (int k = 0; k < g; k++) begin
          a = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
          step(1'b0, 8'h00, a);
        end
        a = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        if (i < 4) step(1'b1, w[31-8*i -: 8], a);
        else       step(1'b1, w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0] ^ {7'd0, ($urandom_range(0, 3) == 0)}, a);
      end
    end

    idle(TO + 3, 3'b111);
    @(negedge Clk);
    #1;
    check("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
